// File: rtl/fadd_issue_if.sv
// Bundle of the upstream, fadd-side and downstream signals of the fadd issue/collect stage.
// slave = the issue stage itself, master = whatever surrounds it (upstream, fadd, consumer).
interface fadd_issue_if #(
    parameter int N     = 16,
    parameter int TAG_W = 4
);
    // Handshakes (in_*, out_*): a transfer happens on a rising clock edge where valid and
    // ready are both 1; valid must not depend combinationally on ready, and a source that
    // raised valid keeps its payload stable until the transfer.
    logic             in_valid;
    logic             in_ready;
    logic [N-1:0]     in_a;
    logic [N-1:0]     in_b;
    logic [TAG_W-1:0] in_tag;
    logic             flush;

    logic [N-1:0]     add_a;
    logic [N-1:0]     add_b;
    logic             add_go;
    logic [N-1:0]     add_sum;

    logic             out_valid;
    logic             out_ready;
    logic [N-1:0]     out_sum;
    logic [TAG_W-1:0] out_tag;
    logic             busy;

    modport slave (
        input  in_valid, in_a, in_b, in_tag, flush, add_sum, out_ready,
        output in_ready, add_a, add_b, add_go, out_valid, out_sum, out_tag, busy
    );

    modport master (
        output in_valid, in_a, in_b, in_tag, flush, add_sum, out_ready,
        input  in_ready, add_a, add_b, add_go, out_valid, out_sum, out_tag, busy
    );
endinterface

// File: rtl/fadd_issue.sv
// Issue/collect stage around a LAT-cycle fadd: zero bypass, tagged in-order results, credit flow.
// Optional FADD_ISSUE_STATS_EN adds saturating launch/bypass counters (stat_issued, stat_bypassed).
module fadd_issue #(
    parameter int N       = 16,
    parameter int EXP_MSB = 14,
    parameter int MAN_MSB = 6,
    parameter int LAT     = 3,
    parameter int DEPTH   = 4,
    parameter int TAG_W   = 4
) (
    input  logic         clock,
    input  logic         nreset,
    fadd_issue_if.slave  bus,
    output logic [1:0]   dbg_state_o
`ifdef FADD_ISSUE_STATS_EN
    ,
    output logic [15:0]  stat_issued,
    output logic [15:0]  stat_bypassed
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic             rdy_en_q;
    logic [CNT_W-1:0] cred_q, cred_d;

    logic             accept;
    logic             a_zero, b_zero, bypass;
    logic [N-1:0]     byp_val;

    logic             add_go_q;
    logic [N-1:0]     add_a_q, add_b_q;

    logic [LAT:0]     pv_q;
    logic [LAT:0]     pb_q;
    logic [TAG_W-1:0] pt_q [LAT+1];
    logic [N-1:0]     pd_q [LAT+1];

    logic             push, pop;
    logic [N-1:0]     push_sum;
    logic [N-1:0]     mem_sum_q [DEPTH];
    logic [TAG_W-1:0] mem_tag_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             out_valid;
    logic             busy;

    // Sign is ignored: +0 and -0 both count as zero.
    assign a_zero  = ~|bus.in_a[EXP_MSB:MAN_MSB+1] && ~|bus.in_a[MAN_MSB:0];
    assign b_zero  = ~|bus.in_b[EXP_MSB:MAN_MSB+1] && ~|bus.in_b[MAN_MSB:0];
    assign bypass  = a_zero || b_zero;
    assign byp_val = (a_zero && !b_zero) ? bus.in_b : bus.in_a;

    // rdy_en_q keeps in_ready low while reset is asserted and for the first cycle after.
    assign bus.in_ready = rdy_en_q && (state_q != ST_FLUSH) && (cred_q != '0) && !bus.flush;
    assign accept       = bus.in_valid && bus.in_ready;

    assign push      = pv_q[LAT];
    assign push_sum  = pb_q[LAT] ? pd_q[LAT] : bus.add_sum;
    assign out_valid = (cnt_q != '0);
    assign pop       = out_valid && bus.out_ready;
    assign busy      = (|pv_q) || out_valid;

    assign bus.out_valid = out_valid;
    assign bus.out_sum   = out_valid ? mem_sum_q[rd_ptr_q] : '0;
    assign bus.out_tag   = out_valid ? mem_tag_q[rd_ptr_q] : '0;
    assign bus.busy      = busy;
    assign bus.add_go    = add_go_q;
    assign bus.add_a     = add_a_q;
    assign bus.add_b     = add_b_q;
    assign dbg_state_o   = state_q;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (accept) state_d = ST_RUN;
            ST_RUN:   if (!busy && !accept) state_d = ST_IDLE;
            ST_FLUSH: if (!busy && !bus.flush) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
        if (bus.flush) state_d = ST_FLUSH;
    end

    // One credit per result slot downstream of accept (pipe plus FIFO), returned on pop.
    always_comb begin
        cred_d = cred_q;
        unique case ({accept, pop})
            2'b10:   cred_d = cred_q - CNT_W'(1);
            2'b01:   cred_d = cred_q + CNT_W'(1);
            default: cred_d = cred_q;
        endcase
    end

    always_comb begin
        cnt_d = cnt_q;
        unique case ({push, pop})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            state_q  <= ST_IDLE;
            rdy_en_q <= 1'b0;
            cred_q   <= CNT_W'(DEPTH);
        end else begin
            state_q  <= state_d;
            rdy_en_q <= 1'b1;
            cred_q   <= cred_d;
        end
    end

    // add_a/add_b only change on a launch so fadd sees stable operands between pulses.
    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            add_go_q <= 1'b0;
            add_a_q  <= '0;
            add_b_q  <= '0;
        end else begin
            add_go_q <= accept && !bypass;
            if (accept && !bypass) begin
                add_a_q <= bus.in_a;
                add_b_q <= bus.in_b;
            end
        end
    end

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            pv_q <= '0;
        end else begin
            pv_q <= {pv_q[LAT-1:0], accept};
        end
    end

    // Payload of the order pipe is qualified by pv_q and needs no reset.
    always_ff @(posedge clock) begin
        pb_q    <= {pb_q[LAT-1:0], bypass};
        pt_q[0] <= bus.in_tag;
        pd_q[0] <= byp_val;
        for (int i = 1; i <= LAT; i++) begin
            pt_q[i] <= pt_q[i-1];
            pd_q[i] <= pd_q[i-1];
        end
    end

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            cnt_q <= cnt_d;
        end
    end

    // A push onto a full FIFO only coincides with a pop, so the overwritten slot is the head.
    always_ff @(posedge clock) begin
        if (push) begin
            mem_sum_q[wr_ptr_q] <= push_sum;
            mem_tag_q[wr_ptr_q] <= pt_q[LAT];
        end
    end

`ifdef FADD_ISSUE_STATS_EN
    logic [15:0] issued_q, bypassed_q;

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            issued_q   <= '0;
            bypassed_q <= '0;
        end else begin
            if (add_go_q && (issued_q != 16'hFFFF))
                issued_q <= issued_q + 16'd1;
            if (accept && bypass && (bypassed_q != 16'hFFFF))
                bypassed_q <= bypassed_q + 16'd1;
        end
    end

    assign stat_issued   = issued_q;
    assign stat_bypassed = bypassed_q;
`endif

endmodule

// File: tb/tb_fadd_issue.sv
// Randomised bench for fadd_issue with a behavioural bf16 adder standing in for fadd.
module tb_fadd_issue;
    localparam int N     = 16;
    localparam int TAG_W = 4;
    localparam int LAT   = 3;
    localparam int DEPTH = 4;

    typedef struct {
        int               c;
        logic [TAG_W-1:0] tag;
        logic [N-1:0]     sum;
    } obs_t;

    logic       clock  = 1'b0;
    logic       nreset = 1'b0;
    logic [1:0] dbg_state;
    int         cyc     = 0;
    int         n_tests = 0;
    int         n_fail  = 0;

    logic [TAG_W+N-1:0] exp_q[$];
    obs_t               obs_q[$];
    int                 go_q[$];
    logic [N-1:0]       fq [LAT];

    fadd_issue_if #(.N(N), .TAG_W(TAG_W)) bus ();

`ifdef FADD_ISSUE_STATS_EN
    logic [15:0] stat_issued, stat_bypassed;
`endif

    fadd_issue #(
        .N(N), .EXP_MSB(14), .MAN_MSB(6), .LAT(LAT), .DEPTH(DEPTH), .TAG_W(TAG_W)
    ) dut (
        .clock       (clock),
        .nreset      (nreset),
        .bus         (bus.slave),
        .dbg_state_o (dbg_state)
`ifdef FADD_ISSUE_STATS_EN
        ,
        .stat_issued   (stat_issued),
        .stat_bypassed (stat_bypassed)
`endif
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    // ---------------- reference arithmetic (bf16 via real) ----------------
    function automatic real bf2r(input logic [15:0] x);
        real r;
        int  e;
        e = int'(x[14:7]);
        if (e == 0) return 0.0;
        r = 1.0 + real'(x[6:0]) / 128.0;
        while (e > 127) begin r = r * 2.0; e--; end
        while (e < 127) begin r = r / 2.0; e++; end
        return x[15] ? -r : r;
    endfunction

    function automatic logic [15:0] r2bf(input real v);
        real  r;
        int   e, m;
        logic s;
        if (v == 0.0) return 16'h0000;
        s = (v < 0.0);
        r = s ? -v : v;
        e = 127;
        while (r >= 2.0 && e < 254) begin r = r / 2.0; e++; end
        while (r < 1.0 && e > 1) begin r = r * 2.0; e--; end
        m = $rtoi((r - 1.0) * 128.0);
        if (m < 0) m = 0;
        if (m > 127) m = 127;
        return {s, 8'(e), 7'(m)};
    endfunction

    function automatic logic [15:0] fadd_model(input logic [15:0] a, input logic [15:0] b);
        return r2bf(bf2r(a) + bf2r(b));
    endfunction

    function automatic logic [N-1:0] ref_result(input logic [N-1:0] a, input logic [N-1:0] b);
        bit az, bz;
        az = (a[14:0] == 15'd0);
        bz = (b[14:0] == 15'd0);
        if (az && !bz) return b;
        if (az || bz) return a;
        return fadd_model(a, b);
    endfunction

    function automatic logic [N-1:0] rand_num();
        return {1'($urandom_range(0, 1)), 8'($urandom_range(110, 140)), 7'($urandom_range(0, 127))};
    endfunction

    function automatic logic [N-1:0] rand_zero();
        return {1'($urandom_range(0, 1)), 15'd0};
    endfunction

    // ---------------- fadd stand-in: result LAT cycles after add_go ----------------
    always @(posedge clock) begin
        fq[0] <= bus.add_go ? fadd_model(bus.add_a, bus.add_b) : 16'hDEAD;
        for (int i = 1; i < LAT; i++) fq[i] <= fq[i-1];
    end
    assign bus.add_sum = fq[LAT-1];

    // ---------------- monitor: log output transfers and launches ----------------
    always @(negedge clock) begin
        #2;
        if (bus.out_valid && bus.out_ready) obs_q.push_back('{cyc, bus.out_tag, bus.out_sum});
        if (bus.add_go) go_q.push_back(cyc);
    end

    // ---------------- drivers ----------------
    task automatic init_inputs();
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.in_tag    = '0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b0;
    endtask

    task automatic send(input logic [N-1:0] a, input logic [N-1:0] b, input logic [TAG_W-1:0] t,
                        input int max_wait, output int acc_cyc, output bit ok);
        @(negedge clock);
        bus.in_valid = 1'b1;
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_tag   = t;
        #1;
        ok      = 1'b0;
        acc_cyc = -1;
        for (int i = 0; i < max_wait; i++) begin
            if (i > 0) begin @(negedge clock); #1; end
            if (bus.in_ready) begin
                ok      = 1'b1;
                acc_cyc = cyc;
                exp_q.push_back({t, ref_result(a, b)});
                break;
            end
        end
        if (!ok) bus.in_valid = 1'b0;
    endtask

    task automatic idle();
        @(negedge clock);
        bus.in_valid = 1'b0;
    endtask

    task automatic clear_logs();
        obs_q.delete();
        go_q.delete();
        exp_q.delete();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        repeat (2) @(negedge clock);
        bus.in_valid = 1'b1;
        #1;
        n_tests++; if (bus.in_ready !== 1'b0)  begin n_fail++; $display("FAIL reset_in_ready got %b want 0", bus.in_ready); end
        n_tests++; if (bus.add_go !== 1'b0)    begin n_fail++; $display("FAIL reset_add_go got %b want 0", bus.add_go); end
        n_tests++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid); end
        n_tests++; if (bus.busy !== 1'b0)      begin n_fail++; $display("FAIL reset_busy got %b want 0", bus.busy); end
        n_tests++; if (dbg_state !== 2'd0)     begin n_fail++; $display("FAIL reset_state got %0d want 0", dbg_state); end
        bus.in_valid = 1'b0;
        @(negedge clock);
        nreset = 1'b1;
        @(negedge clock);
        #1;
        n_tests++; if (bus.in_ready !== 1'b1)  begin n_fail++; $display("FAIL post_reset_in_ready got %b want 1", bus.in_ready); end
        clear_logs();
    endtask

    task automatic test_single_add();
        int c0; bit ok;
        clear_logs();
        bus.out_ready = 1'b1;
        send(16'h3F80, 16'h3F80, 4'd1, 5, c0, ok);
        idle();
        repeat (LAT + 4) @(negedge clock);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL single_accept got ok=%0d want 1", ok); end
        n_tests++;
        if (go_q.size() != 1 || go_q[0] != c0 + 1) begin
            n_fail++; $display("FAIL single_add_go got count=%0d cyc=%0d want count=1 cyc=%0d", go_q.size(), (go_q.size() > 0) ? go_q[0] : -1, c0 + 1);
        end
        n_tests++;
        if (obs_q.size() != 1 || obs_q[0].c != c0 + LAT + 2) begin
            n_fail++; $display("FAIL single_latency got count=%0d cyc=%0d want count=1 cyc=%0d", obs_q.size(), (obs_q.size() > 0) ? obs_q[0].c : -1, c0 + LAT + 2);
        end
        n_tests++;
        if (obs_q.size() < 1 || obs_q[0].sum !== 16'h4000 || obs_q[0].tag !== 4'd1) begin
            n_fail++; $display("FAIL single_result got sum=%h tag=%0d want sum=4000 tag=1", (obs_q.size() > 0) ? obs_q[0].sum : 16'hxxxx, (obs_q.size() > 0) ? obs_q[0].tag : 4'hx);
        end
        clear_logs();
    endtask

    task automatic test_bypass();
        int c0; bit ok;
        clear_logs();
        bus.out_ready = 1'b1;
        send(16'h0000, 16'hBF80, 4'd2, 5, c0, ok);
        idle();
        repeat (LAT + 4) @(negedge clock);
        n_tests++; if (go_q.size() != 0) begin n_fail++; $display("FAIL bypass_no_go got %0d launches want 0", go_q.size()); end
        n_tests++;
        if (obs_q.size() != 1 || obs_q[0].c != c0 + LAT + 2) begin
            n_fail++; $display("FAIL bypass_latency got count=%0d cyc=%0d want count=1 cyc=%0d", obs_q.size(), (obs_q.size() > 0) ? obs_q[0].c : -1, c0 + LAT + 2);
        end
        n_tests++;
        if (obs_q.size() < 1 || obs_q[0].sum !== 16'hBF80 || obs_q[0].tag !== 4'd2) begin
            n_fail++; $display("FAIL bypass_result got sum=%h tag=%0d want sum=bf80 tag=2", (obs_q.size() > 0) ? obs_q[0].sum : 16'hxxxx, (obs_q.size() > 0) ? obs_q[0].tag : 4'hx);
        end
        clear_logs();
    endtask

    task automatic test_back_to_back();
        int c0, acc; bit ok; obs_t o; logic [TAG_W+N-1:0] e;
        clear_logs();
        bus.out_ready = 1'b0;
        acc = 0;
        for (int i = 0; i < 8; i++) begin
            send(rand_num(), rand_num(), 4'(i), 1, c0, ok);
            if (ok) acc++;
        end
        idle();
        #1;
        n_tests++; if (acc != DEPTH) begin n_fail++; $display("FAIL b2b_accepted got %0d want %0d", acc, DEPTH); end
        n_tests++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_in_ready got %b want 0", bus.in_ready); end
        repeat (LAT + 3) @(negedge clock);
        bus.out_ready = 1'b1;
        repeat (DEPTH + 3) @(negedge clock);
        for (int k = 1; k < obs_q.size(); k++) begin
            n_tests++;
            if (obs_q[k].c != obs_q[0].c + k) begin n_fail++; $display("FAIL b2b_rate entry %0d cyc=%0d want %0d", k, obs_q[k].c, obs_q[0].c + k); end
        end
        while (obs_q.size() > 0) begin
            o = obs_q.pop_front();
            n_tests++;
            if (exp_q.size() == 0) begin n_fail++; $display("FAIL b2b_extra got tag=%0d sum=%h want none", o.tag, o.sum); end
            else begin
                e = exp_q.pop_front();
                if ({o.tag, o.sum} !== e) begin n_fail++; $display("FAIL b2b_order got tag=%0d sum=%h want tag=%0d sum=%h", o.tag, o.sum, e[N+TAG_W-1:N], e[N-1:0]); end
            end
        end
        n_tests++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL b2b_lost got %0d missing want 0", exp_q.size()); end
        clear_logs();
    endtask

    task automatic test_mixed_order();
        int c0; bit ok; obs_t o; logic [TAG_W+N-1:0] e; logic [N-1:0] a, b;
        clear_logs();
        bus.out_ready = 1'b1;
        for (int t = 0; t < 6; t++) begin
            a = rand_num();
            b = rand_num();
            if (t % 4 == 0) a = rand_zero();
            if (t % 4 == 2) b = rand_zero();
            send(a, b, 4'(t), 5, c0, ok);
        end
        idle();
        repeat (LAT + 6) @(negedge clock);
        n_tests++; if (go_q.size() != 3) begin n_fail++; $display("FAIL mix_launches got %0d want 3", go_q.size()); end
        while (obs_q.size() > 0) begin
            o = obs_q.pop_front();
            n_tests++;
            if (exp_q.size() == 0) begin n_fail++; $display("FAIL mix_extra got tag=%0d sum=%h want none", o.tag, o.sum); end
            else begin
                e = exp_q.pop_front();
                if ({o.tag, o.sum} !== e) begin n_fail++; $display("FAIL mix_order got tag=%0d sum=%h want tag=%0d sum=%h", o.tag, o.sum, e[N+TAG_W-1:N], e[N-1:0]); end
            end
        end
        n_tests++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL mix_lost got %0d missing want 0", exp_q.size()); end
        clear_logs();
    endtask

    task automatic test_flush();
        int c0, wait_n; bit ok; obs_t o; logic [TAG_W+N-1:0] e;
        clear_logs();
        bus.out_ready = 1'b1;
        for (int t = 0; t < 3; t++) send(rand_num(), rand_num(), 4'(t + 8), 5, c0, ok);
        @(negedge clock);
        bus.in_a   = rand_num();
        bus.in_b   = rand_num();
        bus.in_tag = 4'hF;
        bus.flush  = 1'b1;
        #1;
        n_tests++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL flush_in_ready got %b want 0", bus.in_ready); end
        n_tests++; if (bus.busy !== 1'b1)     begin n_fail++; $display("FAIL flush_busy_high got %b want 1", bus.busy); end
        @(negedge clock);
        #1;
        n_tests++; if (dbg_state !== 2'd2) begin n_fail++; $display("FAIL flush_state got %0d want 2", dbg_state); end
        bus.in_valid = 1'b0;
        wait_n = 0;
        while (bus.busy && wait_n < 20) begin @(negedge clock); #1; wait_n++; end
        n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL flush_drain busy=%b after %0d cycles want 0", bus.busy, wait_n); end
        @(negedge clock);
        #1;
        n_tests++; if (dbg_state !== 2'd2) begin n_fail++; $display("FAIL flush_hold_state got %0d want 2", dbg_state); end
        bus.flush = 1'b0;
        @(negedge clock);
        #1;
        n_tests++; if (dbg_state !== 2'd0) begin n_fail++; $display("FAIL flush_to_idle got %0d want 0", dbg_state); end
        while (obs_q.size() > 0) begin
            o = obs_q.pop_front();
            n_tests++;
            if (exp_q.size() == 0) begin n_fail++; $display("FAIL flush_extra got tag=%0d sum=%h want none", o.tag, o.sum); end
            else begin
                e = exp_q.pop_front();
                if ({o.tag, o.sum} !== e) begin n_fail++; $display("FAIL flush_order got tag=%0d sum=%h want tag=%0d sum=%h", o.tag, o.sum, e[N+TAG_W-1:N], e[N-1:0]); end
            end
        end
        n_tests++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL flush_lost got %0d missing want 0", exp_q.size()); end
        clear_logs();
    endtask

    task automatic test_reset_mid();
        int c0; bit ok;
        clear_logs();
        bus.out_ready = 1'b1;
        send(rand_num(), rand_num(), 4'd3, 5, c0, ok);
        send(rand_zero(), rand_num(), 4'd4, 5, c0, ok);
        idle();
        nreset = 1'b0;
        #1;
        n_tests++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mid_out_valid got %b want 0", bus.out_valid); end
        n_tests++; if (bus.busy !== 1'b0)      begin n_fail++; $display("FAIL rst_mid_busy got %b want 0", bus.busy); end
        n_tests++; if (bus.add_go !== 1'b0)    begin n_fail++; $display("FAIL rst_mid_add_go got %b want 0", bus.add_go); end
        n_tests++; if (bus.in_ready !== 1'b0)  begin n_fail++; $display("FAIL rst_mid_in_ready got %b want 0", bus.in_ready); end
        repeat (2) @(negedge clock);
        nreset = 1'b1;
        clear_logs();
        repeat (LAT + 8) @(negedge clock);
        n_tests++; if (obs_q.size() != 0) begin n_fail++; $display("FAIL rst_mid_ghost got %0d results want 0", obs_q.size()); end
        n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL rst_mid_idle busy=%b want 0", bus.busy); end
        clear_logs();
    endtask

    task automatic test_random();
        int c0; bit ok, done; obs_t o; logic [TAG_W+N-1:0] e; logic [N-1:0] a, b;
        clear_logs();
        done = 1'b0;
        fork
            begin
                for (int k = 0; k < 60; k++) begin
                    a = ($urandom_range(0, 3) == 0) ? rand_zero() : rand_num();
                    b = ($urandom_range(0, 3) == 0) ? rand_zero() : rand_num();
                    send(a, b, 4'($urandom_range(0, 15)), 50, c0, ok);
                    if (!ok) begin n_tests++; n_fail++; $display("FAIL rand_accept_timeout op %0d", k); end
                    if ($urandom_range(0, 3) == 0) idle();
                end
                idle();
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(negedge clock);
                    bus.out_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        bus.out_ready = 1'b1;
        repeat (LAT + DEPTH + 6) @(negedge clock);
        while (obs_q.size() > 0) begin
            o = obs_q.pop_front();
            n_tests++;
            if (exp_q.size() == 0) begin n_fail++; $display("FAIL rand_extra got tag=%0d sum=%h want none", o.tag, o.sum); end
            else begin
                e = exp_q.pop_front();
                if ({o.tag, o.sum} !== e) begin n_fail++; $display("FAIL rand_result got tag=%0d sum=%h want tag=%0d sum=%h", o.tag, o.sum, e[N+TAG_W-1:N], e[N-1:0]); end
            end
        end
        n_tests++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL rand_lost got %0d missing want 0", exp_q.size()); end
        #1;
        n_tests++; if (bus.busy !== 1'b0 || dbg_state !== 2'd0) begin n_fail++; $display("FAIL rand_end_idle busy=%b state=%0d want 0/0", bus.busy, dbg_state); end
        clear_logs();
    endtask

    initial begin
        init_inputs();
        test_reset();
        test_single_add();
        test_bypass();
        test_back_to_back();
        test_mixed_order();
        test_flush();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL global_timeout at cycle %0d", cyc);
        $fatal(1, "timeout");
    end
endmodule
